cam_cmd_scheduler: RTL and testbench

Sequences camera configuration commands from the command map onto the shared camera I2C master, one register write at a time. Queues up to FIFO_DEPTH commands, issues each write, handles NACK retry and timeout, then applies the command's RGB/compression mode and optional capture trigger only after the write succeeds. Sits between the command-map decoder and the camera I2C master / capture path.

---
 rtl/cam_cmd_pkg.sv | 29 ++
 rtl/cam_cmd_fifo.sv | 54 +++++
 rtl/cam_cmd_scheduler.sv | 177 +++++++++++++++++
 tb/tb_cam_cmd_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cmd_pkg.sv
// Shared types for the camera command scheduler: FSM states, the queued
// command record and the NOP register address.
package cam_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_APPLY
  } state_e;

  // One queued command, 28 bits.
  typedef struct packed {
    logic [7:0]  saddr;
    logic [15:0] sdata;
    logic        rgb;
    logic [1:0]  compression;
    logic        trigger;
  } cam_cmd_t;

  // Register address meaning "apply mode only, skip the I2C write".
  localparam logic [7:0] CAM_SADDR_NOP = 8'hFF;

  // Saturating 8-bit increment for the failure counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cam_cmd_fifo.sv
// Synchronous command queue. Push is ignored when full, pop when empty.
// Pointers wrap naturally because DEPTH is a power of two; the occupancy
// counter holds DEPTH+1 values so full and empty are unambiguous.
module cam_cmd_fifo
  import cam_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  cam_cmd_t din,
  output cam_cmd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cam_cmd_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cam_cmd_scheduler.sv
// Camera command scheduler: queues commands, issues one I2C register write
// at a time, handles NACK/timeout, and applies the command's mode and
// capture trigger only once the write has succeeded.
// Optional feature macro: CAM_CMD_RETRY_EN (retry NACKed writes up to
// MAX_RETRIES times; when undefined the first NACK fails the command).
module cam_cmd_scheduler
  import cam_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_saddr,
  input  logic [15:0] cmd_sdata,
  input  logic        cmd_rgb,
  input  logic [1:0]  cmd_compression,
  input  logic        cmd_trigger,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        i2c_start,
  output logic [7:0]  i2c_saddr,
  output logic [15:0] i2c_sdata,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        rgb_to_cam,
  output logic [1:0]  compression_to_cam,
  output logic        trigger_to_cam,
  output logic        sched_busy,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [7:0]  err_count
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("MAX_RETRIES must be in 1..15");
  end

  state_e        state_q;
  cam_cmd_t      cur_q, fifo_dout, fifo_din;
  logic [TW-1:0] tmo_q;
  logic          start_q, rgb_q, trig_q, err_flag_q;
  logic [1:0]    comp_q;
  logic [7:0]    err_cnt_q;
  logic          fifo_full, fifo_empty, push, pop;
  logic          fail_now, retry_now;

  assign fifo_din  = '{saddr: cmd_saddr, sdata: cmd_sdata, rgb: cmd_rgb,
                       compression: cmd_compression, trigger: cmd_trigger};
  // Ready reflects pre-pop occupancy, so a full queue refuses even while popping.
  assign cmd_ready = ~fifo_full & ~rst;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == S_IDLE) & ~fifo_empty;

  cam_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef CAM_CMD_RETRY_EN
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRIES);
  logic [3:0] retry_q;

  // NACK retry count for the command in flight; cleared once it leaves ISSUE/WAIT.
  always_ff @(posedge clk) begin
    if (rst)                                        retry_q <= '0;
    else if (retry_now)                             retry_q <= retry_q + 4'd1;
    else if (state_q != S_WAIT && state_q != S_ISSUE) retry_q <= '0;
  end
`endif

  // Decide this cycle's WAIT outcome: retry the write, or give up on the command.
  always_comb begin
    fail_now  = 1'b0;
    retry_now = 1'b0;
    if (state_q == S_WAIT) begin
      if (i2c_done) begin
        if (i2c_ack_err) begin
`ifdef CAM_CMD_RETRY_EN
          if (retry_q < RETRY_LIM) retry_now = 1'b1;
          else                     fail_now  = 1'b1;
`else
          fail_now = 1'b1;
`endif
        end
      end else if (tmo_q == TMO_LAST) begin
        fail_now = 1'b1;
      end
    end
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      rgb_q      <= 1'b0;
      comp_q     <= 2'd0;
      trig_q     <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      start_q <= 1'b0;
      trig_q  <= 1'b0;

      // A failure in the same cycle as err_clr leaves exactly one recorded failure.
      if (fail_now) begin
        err_flag_q <= 1'b1;
        err_cnt_q  <= err_clr ? 8'd1 : sat_inc8(err_cnt_q);
      end else if (err_clr) begin
        err_flag_q <= 1'b0;
        err_cnt_q  <= 8'd0;
      end

      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_q <= fifo_dout;
            if (fifo_dout.saddr == CAM_SADDR_NOP) begin
              state_q <= S_APPLY;
            end else begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (retry_now) begin
            state_q <= S_ISSUE;
            start_q <= 1'b1;
          end else if (fail_now) begin
            state_q <= S_IDLE;
          end else if (i2c_done) begin
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          rgb_q   <= cur_q.rgb;
          comp_q  <= cur_q.compression;
          trig_q  <= cur_q.trigger;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign i2c_start          = start_q;
  assign i2c_saddr          = cur_q.saddr;
  assign i2c_sdata          = cur_q.sdata;
  assign rgb_to_cam         = rgb_q;
  assign compression_to_cam = comp_q;
  assign trigger_to_cam     = trig_q;
  assign sched_busy         = (state_q != S_IDLE) | ~fifo_empty;
  assign err_flag           = err_flag_q;
  assign err_count          = err_cnt_q;

endmodule

// File: tb/tb_cam_cmd_scheduler.sv
// Directed bench for cam_cmd_scheduler with a small I2C master responder.
// Expected values follow the macro CAM_CMD_RETRY_EN as compiled.
module tb_cam_cmd_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_saddr = '0;
  logic [15:0] cmd_sdata = '0;
  logic        cmd_rgb = 1'b0, cmd_trigger = 1'b0, cmd_valid = 1'b0;
  logic [1:0]  cmd_compression = '0;
  logic        cmd_ready, i2c_start, i2c_done = 1'b0, i2c_ack_err = 1'b0;
  logic [7:0]  i2c_saddr;
  logic [15:0] i2c_sdata;
  logic        rgb_to_cam, trigger_to_cam, sched_busy, err_clr = 1'b0, err_flag;
  logic [1:0]  compression_to_cam;
  logic [7:0]  err_count;

  cam_cmd_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .MAX_RETRIES(3)) dut (
    .clk(clk), .rst(rst), .cmd_saddr(cmd_saddr), .cmd_sdata(cmd_sdata),
    .cmd_rgb(cmd_rgb), .cmd_compression(cmd_compression), .cmd_trigger(cmd_trigger),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .i2c_start(i2c_start),
    .i2c_saddr(i2c_saddr), .i2c_sdata(i2c_sdata), .i2c_done(i2c_done),
    .i2c_ack_err(i2c_ack_err), .rgb_to_cam(rgb_to_cam),
    .compression_to_cam(compression_to_cam), .trigger_to_cam(trigger_to_cam),
    .sched_busy(sched_busy), .err_clr(err_clr), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int starts = 0, trig_cnt = 0;
  bit resp_en = 1'b1;
  int resp_delay = 5;
  int nack_left = 0;
  logic [23:0] log_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // I2C master model: sees start at negedge, answers resp_delay cycles later.
  initial begin
    bit again;
    forever begin
      @(negedge clk);
      again = i2c_start;
      while (again) begin
        starts++;
        log_q.push_back({i2c_saddr, i2c_sdata});
        again = 1'b0;
        if (resp_en) begin
          repeat (resp_delay) @(negedge clk);
          i2c_done    = 1'b1;
          i2c_ack_err = (nack_left > 0);
          if (nack_left > 0) nack_left--;
          @(negedge clk);
          i2c_done    = 1'b0;
          i2c_ack_err = 1'b0;
          again = i2c_start;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (trigger_to_cam) trig_cnt++;
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [7:0] a, input logic [15:0] d, input logic r,
                      input logic [1:0] c, input logic t);
    int n = 0;
    cmd_saddr = a; cmd_sdata = d; cmd_rgb = r; cmd_compression = c; cmd_trigger = t;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_ready_timeout", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (sched_busy && n < 3000) begin @(negedge clk); n++; end
    chk(tag, sched_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  logic [23:0] exp_log [6];
  int base, n;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    chk("ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_start", i2c_start, 0);
    chk("rst_addr_data", {i2c_saddr, i2c_sdata}, 0);
    chk("rst_modes", {rgb_to_cam, compression_to_cam, trigger_to_cam}, 0);
    chk("rst_busy", sched_busy, 0);
    chk("rst_err", {err_flag, err_count}, 0);

    // Single write, done 5 cycles after start
    resp_delay = 5;
    push(8'h12, 16'h8040, 1'b1, 2'd2, 1'b1);    // now cycle 1
    chk("t1_c1_start", i2c_start, 0);
    chk("t1_c1_busy", sched_busy, 1);
    @(negedge clk);                               // cycle 2
    chk("t1_c2_start", i2c_start, 1);
    chk("t1_c2_addr", {i2c_saddr, i2c_sdata}, 24'h128040);
    repeat (6) @(negedge clk);                    // cycle 8 (APPLY)
    chk("t1_c8_rgb", rgb_to_cam, 0);
    @(negedge clk);                               // cycle 9
    chk("t1_c9_mode", {rgb_to_cam, compression_to_cam}, 3'b110);
    chk("t1_c9_trig", trigger_to_cam, 1);
    @(negedge clk);
    chk("t1_c10_trig", trigger_to_cam, 0);
    wait_idle("t1_idle");
    chk("t1_starts", starts, 1);
    chk("t1_trig_cnt", trig_cnt, 1);
    chk("t1_err", err_count, 0);

    // Blocker plus five back-to-back commands into a depth-4 queue
    log_q.delete();
    starts = 0;
    resp_delay = 8;
    exp_log[0] = 24'h200001; exp_log[1] = 24'h211111; exp_log[2] = 24'h222222;
    exp_log[3] = 24'h233333; exp_log[4] = 24'h244444; exp_log[5] = 24'h255555;
    for (int i = 0; i < 5; i++)
      push(exp_log[i][23:16], exp_log[i][15:0], 1'b0, 2'd0, 1'b0);
    // cycle 5: blocker in WAIT, four queued, fifth must be held
    cmd_saddr = exp_log[5][23:16]; cmd_sdata = exp_log[5][15:0];
    cmd_rgb = 1'b1; cmd_compression = 2'd3; cmd_trigger = 1'b0; cmd_valid = 1'b1;
    chk("t2_full_ready", cmd_ready, 0);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("t2_held_cycles", n, 8);
    chk("t2_first_pop_addr", i2c_saddr, 8'h21);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle("t2_idle");
    chk("t2_starts", starts, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_order%0d", i), (log_q.size() > i) ? log_q[i] : 24'h0, exp_log[i]);
    chk("t2_mode", {rgb_to_cam, compression_to_cam}, 3'b111);

    // NACK twice then ack
    starts = 0; resp_delay = 3; nack_left = 2;
    push(8'h34, 16'h0102, 1'b0, 2'd1, 1'b0);
    wait_idle("t3_idle");
`ifdef CAM_CMD_RETRY_EN
    chk("t3_starts", starts, 3);
    chk("t3_mode", {rgb_to_cam, compression_to_cam}, 3'b001);
    chk("t3_err", {err_flag, err_count}, 9'h000);
`else
    chk("t3_starts", starts, 1);
    chk("t3_mode", {rgb_to_cam, compression_to_cam}, 3'b111);
    chk("t3_err", {err_flag, err_count}, 9'h101);
`endif
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("t3_err_clr", {err_flag, err_count}, 0);

    // Timeout: no done, failure 16 cycles into WAIT
    nack_left = 0; resp_en = 1'b0; starts = 0;
    push(8'h40, 16'hAAAA, 1'b1, 2'd0, 1'b0);     // cycle 1, start at 2, WAIT 3..18
    repeat (17) @(negedge clk);                   // cycle 18
    chk("t4_c18_err", err_flag, 0);
    @(negedge clk);                               // cycle 19
    chk("t4_c19_err", {err_flag, err_count}, 9'h101);
    chk("t4_busy", sched_busy, 0);
    resp_en = 1'b1; resp_delay = 2;
    push(8'h41, 16'hBBBB, 1'b1, 2'd2, 1'b0);
    wait_idle("t4_idle");
    chk("t4_starts", starts, 2);
    chk("t4_next_mode", {rgb_to_cam, compression_to_cam}, 3'b110);

    // NOP command: mode only
    starts = 0;
    push(8'hFF, 16'h0000, 1'b0, 2'd3, 1'b0);     // cycle 1
    @(negedge clk);                               // cycle 2
    chk("t5_c2_start", i2c_start, 0);
    chk("t5_c2_comp", compression_to_cam, 2);
    @(negedge clk);                               // cycle 3
    chk("t5_c3_mode", {rgb_to_cam, compression_to_cam}, 3'b011);
    wait_idle("t5_idle");
    chk("t5_starts", starts, 0);

    // Reset during WAIT flushes the queue
    resp_en = 1'b0;
    push(8'h50, 16'h5050, 1'b1, 2'd1, 1'b0);
    push(8'h51, 16'h5151, 1'b1, 2'd1, 1'b0);
    push(8'h52, 16'h5252, 1'b1, 2'd1, 1'b0);     // cycle 3, A in WAIT
    chk("t6_pre_addr", i2c_saddr, 8'h50);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_start", i2c_start, 0);
    chk("t6_rst_addr", {i2c_saddr, i2c_sdata}, 0);
    chk("t6_rst_modes", {rgb_to_cam, compression_to_cam, trigger_to_cam}, 0);
    chk("t6_rst_busy", sched_busy, 0);
    chk("t6_rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    base = starts;
    resp_en = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_no_issue", starts, base);
    chk("t6_busy", sched_busy, 0);
    chk("t6_ready", cmd_ready, 1);

    // 256 NACK failures saturate the counter
    resp_delay = 1; nack_left = 1000000;
    for (int i = 0; i < 256; i++) push(8'h60, 16'(i), 1'b1, 2'd1, 1'b0);
    wait_idle("t7_idle");
    chk("t7_sat", {err_flag, err_count}, 9'h1FF);
    chk("t7_mode", {rgb_to_cam, compression_to_cam}, 0);

    // err_clr in the failing cycle
    push(8'h61, 16'h6161, 1'b0, 2'd0, 1'b0);     // cycle 1, start at 2
`ifdef CAM_CMD_RETRY_EN
    repeat (8) @(negedge clk);                    // cycle 9: final NACK
`else
    repeat (2) @(negedge clk);                    // cycle 3: NACK
`endif
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t8_clr_and_fail", {err_flag, err_count}, 9'h101);
    nack_left = 0;
    wait_idle("t8_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
